// File: rtl/cve2_ex_iter_multdiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The slave modport is the unit's view; the master modport is the requester's view.
interface cve2_ex_iter_multdiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             data_ind_timing_i;
  logic             kill_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             busy_o;

  modport master (
    output in_valid_i, op_i, op_a_i, op_b_i, data_ind_timing_i, kill_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_i, op_a_i, op_b_i, data_ind_timing_i, kill_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/cve2_ex_iter_multdiv.sv
// Iterative radix-2 multiplier/divider: operands become magnitudes at accept,
// WIDTH shift-add or restoring-subtract steps run in CALC, and FIXUP restores the sign.
module cve2_ex_iter_multdiv #(
  parameter int WIDTH        = 32,
  parameter bit EarlyDivZero = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  cve2_ex_iter_multdiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               div_zero_q, div_zero_d;
  logic               dit_q, dit_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               is_div_s, b_zero_s, early_s, accept_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s;
  logic [2*WIDTH-1:0] mul_step_s, div_step_s, prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, fix_s;

  assign accept_s = bus.in_valid_i & bus.in_ready_o;

  // Accept-time decode: signedness, magnitudes and the divide-by-zero short path.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s  = a_signed_s & bus.op_a_i[WIDTH-1];
    b_neg_s  = b_signed_s & bus.op_b_i[WIDTH-1];
    a_mag_s  = cond_neg(bus.op_a_i, a_neg_s);
    b_mag_s  = cond_neg(bus.op_b_i, b_neg_s);
    is_div_s = bus.op_i[2];
    b_zero_s = (bus.op_b_i == {WIDTH{1'b0}});
    early_s  = EarlyDivZero & ~bus.data_ind_timing_i & is_div_s & b_zero_s;
  end

  // One radix-2 step; the divide trial keeps an extra bit so the shifted remainder never overflows.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_q};
    mul_step_s  = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_q};
    div_step_s  = div_trial_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign correction and result selection; a zero divisor skips CALC so the remainder comes from A.
  always_comb begin
    prod_s = cond_neg2(acc_q, a_neg_q ^ b_neg_q);
    quot_s = div_zero_q ? {WIDTH{1'b1}} : cond_neg(acc_q[WIDTH-1:0], a_neg_q ^ b_neg_q);
    rem_s  = cond_neg(div_zero_q ? a_mag_q : acc_q[2*WIDTH-1:WIDTH], a_neg_q);
    case (op_q)
      OP_MUL:                     fix_s = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_s = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:            fix_s = quot_s;
      default:                    fix_s = rem_s;
    endcase
  end

  // FSM next state and datapath updates; kill overrides every transition once busy.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    op_d       = op_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    div_zero_d = div_zero_q;
    dit_d      = dit_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d       = bus.op_i;
          a_mag_d    = a_mag_s;
          b_mag_d    = b_mag_s;
          a_neg_d    = a_neg_s;
          b_neg_d    = b_neg_s;
          div_zero_d = is_div_s & b_zero_s;
          dit_d      = bus.data_ind_timing_i;
          cnt_d      = CW'(WIDTH - 1);
          acc_d      = {{WIDTH{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
          state_d    = early_s ? FIXUP : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step_s : mul_step_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIXUP: begin
        result_d = fix_s;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) begin
          state_d  = IDLE;
          result_d = {WIDTH{1'b0}};
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d  = IDLE;
        result_d = {WIDTH{1'b0}};
      end
    endcase
    if (bus.kill_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = {WIDTH{1'b0}};
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      op_q       <= 3'd0;
      a_mag_q    <= {WIDTH{1'b0}};
      b_mag_q    <= {WIDTH{1'b0}};
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      dit_q      <= 1'b0;
      result_q   <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      div_zero_q <= div_zero_d;
      dit_q      <= dit_d;
      result_q   <= result_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE) & ~rst_i;
  assign bus.out_valid_o = (state_q == DONE) & ~bus.kill_i;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.result_o    = result_q;

  logic unused_s;
  assign unused_s = dit_q;

endmodule

// File: tb/tb_cve2_ex_iter_multdiv.sv
// Directed-vector bench for cve2_ex_iter_multdiv: 32-bit instance for the main
// vectors, 8-bit instance for the narrow-width regression.
module tb_cve2_ex_iter_multdiv;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cve2_ex_iter_multdiv_if #(.WIDTH(32)) bus32();
  cve2_ex_iter_multdiv_if #(.WIDTH(8))  bus8();

  cve2_ex_iter_multdiv #(.WIDTH(32), .EarlyDivZero(1'b1)) u_dut32 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus32)
  );

  cve2_ex_iter_multdiv #(.WIDTH(8), .EarlyDivZero(1'b1)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; handshake is left to the caller.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dit, output logic [31:0] res, output int lat);
    @(negedge clk);
    bus32.in_valid_i        = 1'b1;
    bus32.op_i              = op;
    bus32.op_a_i            = a;
    bus32.op_b_i            = b;
    bus32.data_ind_timing_i = dit;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus32.in_valid_i = 1'b0;
        bus32.op_i       = ~op;
        bus32.op_a_i     = ~a;
        bus32.op_b_i     = ~b;
      end
    end while (!bus32.out_valid_o && lat < 200);
    if (!bus32.out_valid_o) check_eq("timeout", 64'd0, 64'd1);
    res = bus32.result_o;
  endtask

  task automatic finish_op();
    bus32.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_after_hs", {62'd0, bus32.busy_o, bus32.in_ready_o}, 64'd1);
  endtask

  task automatic vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic dit, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int l;
    run_op(op, a, b, dit, r, l);
    check_eq(tag, 64'(r), 64'(exp));
    check_eq({tag, "_lat"}, 64'(l), 64'(exp_lat));
    finish_op();
  endtask

  initial begin
    logic [31:0] r;
    int l;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus32.in_valid_i = 1'b0; bus32.op_i = 3'd0; bus32.op_a_i = 32'd0; bus32.op_b_i = 32'd0;
    bus32.data_ind_timing_i = 1'b0; bus32.kill_i = 1'b0; bus32.out_ready_i = 1'b1;
    bus8.in_valid_i = 1'b0; bus8.op_i = 3'd0; bus8.op_a_i = 8'd0; bus8.op_b_i = 8'd0;
    bus8.data_ind_timing_i = 1'b0; bus8.kill_i = 1'b0; bus8.out_ready_i = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(bus32.in_ready_o), 64'd0);
    check_eq("rst_out_valid", 64'(bus32.out_valid_o), 64'd0);
    check_eq("rst_busy", 64'(bus32.busy_o), 64'd0);
    check_eq("rst_result", 64'(bus32.result_o), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", 64'(bus32.in_ready_o), 64'd1);

    // Multiply family
    vec("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 34);
    vec("mulh",    3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 34);
    vec("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 34);
    vec("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 34);
    vec("mulhsu2", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 34);
    vec("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 34);

    // Divide family, overflow and divide-by-zero
    vec("div",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD, 34);
    vec("rem",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 34);
    vec("div_negb", 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 34);
    vec("rem_negb", 3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 34);
    vec("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 34);
    vec("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 34);
    vec("divu",     3'd5, 32'd100, 32'd7, 1'b0, 32'd14, 34);
    vec("remu",     3'd7, 32'd100, 32'd7, 1'b0, 32'd2, 34);
    vec("divu_z_fast", 3'd5, 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 2);
    vec("divu_z_dit",  3'd5, 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 34);
    vec("remu_z",      3'd7, 32'h0000_1234, 32'd0, 1'b0, 32'h0000_1234, 2);
    vec("rem_z_dit",   3'd6, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 34);
    vec("div_z",       3'd4, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFF, 2);

    // Backpressure: result held for 5 cycles
    bus32.out_ready_i = 1'b0;
    run_op(3'd0, 32'd3, 32'd5, 1'b0, r, l);
    check_eq("bp_result", 64'(r), 64'd15);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold", {bus32.out_valid_o, bus32.in_ready_o, bus32.result_o},
               {1'b1, 1'b0, 32'd15});
    end
    finish_op();

    // Kill in CALC cycle 10 with a simultaneous request
    @(negedge clk);
    bus32.in_valid_i = 1'b1; bus32.op_i = 3'd3; bus32.op_a_i = 32'hFFFF_FFFF; bus32.op_b_i = 32'h2;
    bus32.data_ind_timing_i = 1'b0;
    @(posedge clk);
    #1;
    bus32.in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus32.kill_i = 1'b1;
    bus32.in_valid_i = 1'b1;
    #1;
    check_eq("kill_calc_valid", 64'(bus32.out_valid_o), 64'd0);
    @(posedge clk);
    #1;
    bus32.kill_i = 1'b0;
    bus32.in_valid_i = 1'b0;
    check_eq("kill_calc_idle", {62'd0, bus32.busy_o, bus32.in_ready_o}, 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus32.out_valid_o || bus32.busy_o) pulses++;
    end
    check_eq("kill_no_output", 64'(pulses), 64'd0);
    vec("after_kill", 3'd5, 32'd100, 32'd7, 1'b0, 32'd14, 34);

    // Kill in DONE beats the handshake and masks out_valid the same cycle
    bus32.out_ready_i = 1'b0;
    run_op(3'd0, 32'd6, 32'd7, 1'b0, r, l);
    check_eq("kd_result", 64'(r), 64'd42);
    bus32.kill_i = 1'b1;
    bus32.out_ready_i = 1'b1;
    #1;
    check_eq("kill_done_valid", 64'(bus32.out_valid_o), 64'd0);
    @(posedge clk);
    #1;
    bus32.kill_i = 1'b0;
    check_eq("kill_done_idle", {bus32.busy_o, bus32.result_o}, 33'd0);

    // Kill in IDLE must not block a simultaneous accept
    @(negedge clk);
    bus32.kill_i = 1'b1;
    bus32.in_valid_i = 1'b1; bus32.op_i = 3'd0; bus32.op_a_i = 32'd9; bus32.op_b_i = 32'd9;
    @(posedge clk);
    #1;
    bus32.kill_i = 1'b0;
    bus32.in_valid_i = 1'b0;
    check_eq("kill_idle_accept", 64'(bus32.busy_o), 64'd1);
    l = 1;
    while (!bus32.out_valid_o && l < 200) begin
      @(posedge clk);
      #1;
      l++;
    end
    check_eq("kill_idle_result", 64'(bus32.result_o), 64'd81);
    check_eq("kill_idle_lat", 64'(l), 64'd34);
    finish_op();

    // Reset in CALC cycle 5
    @(negedge clk);
    bus32.in_valid_i = 1'b1; bus32.op_i = 3'd0; bus32.op_a_i = 32'd11; bus32.op_b_i = 32'd13;
    @(posedge clk);
    #1;
    bus32.in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("midrst_state", {bus32.in_ready_o, bus32.out_valid_o, bus32.busy_o, bus32.result_o},
             {1'b1, 1'b0, 1'b0, 32'd0});
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus32.out_valid_o) pulses++;
    end
    check_eq("midrst_no_valid", 64'(pulses), 64'd0);

    // 8-bit regression
    @(negedge clk);
    bus8.in_valid_i = 1'b1; bus8.op_i = 3'd0; bus8.op_a_i = 8'h0F; bus8.op_b_i = 8'h0F;
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
      if (l == 1) bus8.in_valid_i = 1'b0;
    end while (!bus8.out_valid_o && l < 50);
    check_eq("w8_mul", 64'(bus8.result_o), 64'hE1);
    check_eq("w8_lat", 64'(l), 64'd10);
    @(posedge clk);
    #1;
    check_eq("w8_idle", 64'(bus8.busy_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cve2_ex_iter_multdiv.md
CVE2_EX_ITER_MULTDIV -- requirements
Module: cve2_ex_iter_multdiv

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL provide parameter EarlyDivZero, default 1: 1 = divide-by-zero short path allowed when data_ind_timing_i=0.
REQ-003 SHALL provide port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port in_valid_i  input  1  operation request.
REQ-006 SHALL provide port in_ready_o  output  1  request accepted when in_valid_i & in_ready_o.
REQ-007 SHALL provide port op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL provide port op_a_i  input  WIDTH  operand A, dividend or multiplicand.
REQ-009 SHALL provide port op_b_i  input  WIDTH  operand B, divisor or multiplier.
REQ-010 SHALL provide port data_ind_timing_i  input  1  sampled at accept; 1 forces the fixed full latency.
REQ-011 SHALL provide port kill_i  input  1  abort of the operation in flight.
REQ-012 SHALL provide port out_valid_o  output  1  result available.
REQ-013 SHALL provide port out_ready_i  input  1  consumer takes the result when out_valid_o & out_ready_i.
REQ-014 SHALL provide port result_o  output  WIDTH  result; value only meaningful while out_valid_o=1.
REQ-015 SHALL provide port busy_o  output  1  high in every state except IDLE.

Function
REQ-016 SHALL latch op, operands (converted to magnitudes, with result-sign flags) and data_ind_timing_i on the accept cycle; later input changes have no effect.
REQ-017 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-018 SHALL drive in_ready_o=1 only in IDLE; no request is accepted in any other state.
REQ-019 Transitions SHALL be:
  - IDLE->CALC on accept.
  - CALC->FIXUP after exactly WIDTH CALC cycles, counted by a down-counter loaded with WIDTH-1.
  - FIXUP->DONE after 1 cycle.
  - DONE->IDLE on out_ready_i=1.
REQ-020 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide, with a 2*WIDTH-bit accumulator.
REQ-021 FIXUP SHALL apply two's-complement sign correction and select the low half (MUL) or high half (MULH*) of the product, or the quotient (DIV*) or remainder (REM*).
REQ-022 Signedness SHALL be:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both signed.
  - MULHU/DIVU/REMU: both unsigned.
REQ-023 Latency SHALL be WIDTH+2 cycles from the accept edge to out_valid_o=1.
REQ-024 Divide by zero (op_b=0) SHALL return all-ones for DIV/DIVU and op_a for REM/REMU.
REQ-025 If EarlyDivZero=1 and latched data_ind_timing=0 and op_b=0 on a divide, the FSM SHALL go IDLE->FIXUP, bypassing CALC (latency 2); otherwise it SHALL take the full latency.
REQ-026 Signed overflow (op_a = most-negative value, op_b = -1) SHALL return the most-negative value for DIV and 0 for REM, at full latency.
REQ-027 result_o and out_valid_o SHALL hold stable in DONE until the handshake.
REQ-028 kill_i=1 SHALL force the FSM to IDLE on the next edge from any state, take priority over every transition including the DONE handshake, and suppress out_valid_o in that cycle.
REQ-029 kill_i=1 in IDLE SHALL have no effect and SHALL NOT block a simultaneous accept; kill_i=1 while busy_o=1 with a simultaneous in_valid_i SHALL NOT accept.

Reset
REQ-030 rst_i=1 SHALL, on the next edge, place the FSM in IDLE, clear the counter, accumulator and latched operands, and override kill_i and in_valid_i.
REQ-031 Output values in reset and IDLE SHALL be: in_ready_o=1 (IDLE only, not during the reset cycle), out_valid_o=0, busy_o=0, result_o=0.
REQ-032 Reset asserted mid-operation SHALL discard the operation with no out_valid_o pulse.

Verification
REQ-033 WIDTH=32: MUL A=0x0000_0007, B=0xFFFF_FFFD -> 0xFFFF_FFEB; MULH of the same operands -> 0xFFFF_FFFF; out_valid_o rises exactly 34 cycles after accept.
REQ-034 MULHU A=B=0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU A=0xFFFF_FFFF, B=0x0000_0002 -> 0xFFFF_FFFF.
REQ-035 DIV A=0xFFFF_FFF9 (-7), B=2 -> 0xFFFF_FFFD; REM of the same operands -> 0xFFFF_FFFF; DIV A=0x8000_0000, B=0xFFFF_FFFF -> 0x8000_0000; REM of the same operands -> 0.
REQ-036 DIVU A=0x1234, B=0 with data_ind_timing_i=0 -> 0xFFFF_FFFF at latency 2; same request with data_ind_timing_i=1 -> same value at latency 34; REMU with B=0 -> 0x1234.
REQ-037 Backpressure and abort:
  - out_ready_i=0 for 5 cycles: result_o and out_valid_o stable throughout; in_ready_o=0 until the handshake.
  - kill_i pulse in CALC cycle 10: FSM in IDLE next cycle, no out_valid_o, and the next request completes correctly.
REQ-038 rst_i asserted in CALC cycle 5 -> FSM in IDLE, no out_valid_o, all outputs at their reset values; WIDTH=8 regression: MUL 0x0F*0x0F -> 0xE1 at latency 10.
